// File: rtl/vga_sync_sink_core_if.sv
// Slot bus between a host processor and the VGA sync sink core.
//   cs      : slot select
//   write   : write strobe (effective only together with cs)
//   read    : read strobe (reads have no side effects)
//   addr    : word address, only addr[1:0] is decoded by the core
//   wr_data : write data
//   rd_data : read data, combinational from addr[1:0]
interface vga_sync_sink_core_if;
    logic        cs;
    logic        write;
    logic        read;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, write, read, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, write, read, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/vga_sync_sink_core.sv
// VGA 640x480 sync generator and pixel sink at the end of a video stream chain.
// Produces the frame counters x/y that feed the upstream chain, then re-times
// the sync and blanking decode by DLY clk cycles so they line up with the
// pixel (si_rgb) returned by the last core in the chain.
//   clk         : sole clock, rising edge
//   reset       : synchronous, active-low
//   slot        : slot bus (enable register, frame counter, y, vblank)
//   x, y        : current frame position
//   si_rgb      : final stream pixel from the chain
//   hsync/vsync : active-low syncs, registered
//   rgb         : pixel to the DAC, registered
//   frame_start : one-clk pulse at the first pixel tick of a frame
module vga_sync_sink_core #(
    parameter int unsigned CD  = 4,
    parameter int unsigned DLY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_sync_sink_core_if.slave   slot,
    output logic [10:0]           x,
    output logic [10:0]           y,
    input  logic [11:0]           si_rgb,
    output logic                  hsync,
    output logic                  vsync,
    output logic [11:0]           rgb,
    output logic                  frame_start
);
    localparam logic [3:0] DIV_LAST = 4'(CD - 1);

    logic [3:0]  div;
    logic        pixel_tick;
    logic [15:0] frame_cnt;
    logic        en_reg;
    logic        h_sync_n;
    logic        v_sync_n;
    logic        video_on;
    logic        h_d;
    logic        v_d;
    logic        vid_d;
    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_clr;
    logic        vblank;
    logic        unused_ok;

    // ---------------- pixel tick divider ----------------
    assign pixel_tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div <= '0;
        end else if (pixel_tick) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    // ---------------- frame counters ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (pixel_tick) begin
            if (x == 11'd799) begin
                x <= '0;
                y <= (y == 11'd524) ? '0 : y + 11'd1;
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    assign frame_start = pixel_tick && (x == '0) && (y == '0);

    // ---------------- slot registers ----------------
    assign wr_en   = slot.cs && slot.write;
    assign wr_ctrl = wr_en && (slot.addr[1:0] == 2'd0);
    assign wr_clr  = wr_en && (slot.addr[1:0] == 2'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_reg <= 1'b1;
        end else if (wr_ctrl) begin
            en_reg <= slot.wr_data[0];
        end
    end

    // Clear has priority over a coincident frame_start increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (wr_clr) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign vblank = (y >= 11'd480);

    always_comb begin
        slot.rd_data = '0;
        case (slot.addr[1:0])
            2'd0: slot.rd_data = {31'b0, en_reg};
            2'd1: slot.rd_data = {16'b0, frame_cnt};
            2'd2: slot.rd_data = {21'b0, y};
            2'd3: slot.rd_data = {31'b0, vblank};
        endcase
    end

    // ---------------- timing decode ----------------
    assign h_sync_n = !((x >= 11'd656) && (x <= 11'd751));
    assign v_sync_n = !((y >= 11'd490) && (y <= 11'd491));
    assign video_on = (x < 11'd640) && (y < 11'd480);

    // ---------------- chain-latency alignment ----------------
    generate
        if (DLY == 0) begin : g_nodly
            assign h_d   = h_sync_n;
            assign v_d   = v_sync_n;
            assign vid_d = video_on;
        end else begin : g_dly
            logic [DLY-1:0] h_sr;
            logic [DLY-1:0] v_sr;
            logic [DLY-1:0] vid_sr;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    h_sr   <= '1;
                    v_sr   <= '1;
                    vid_sr <= '0;
                end else begin
                    h_sr[0]   <= h_sync_n;
                    v_sr[0]   <= v_sync_n;
                    vid_sr[0] <= video_on;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        h_sr[i]   <= h_sr[i-1];
                        v_sr[i]   <= v_sr[i-1];
                        vid_sr[i] <= vid_sr[i-1];
                    end
                end
            end

            assign h_d   = h_sr[DLY-1];
            assign v_d   = v_sr[DLY-1];
            assign vid_d = vid_sr[DLY-1];
        end
    endgenerate

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else begin
            hsync <= h_d;
            vsync <= v_d;
            rgb   <= (vid_d && en_reg) ? si_rgb : '0;
        end
    end

    // Undecoded slot bits and the side-effect-free read strobe.
    assign unused_ok = &{1'b0, slot.read, slot.addr[13:2], slot.wr_data[31:1]};
endmodule

// File: tb/tb_vga_sync_sink_core.sv
// Self-checking bench for vga_sync_sink_core (CD=4, DLY=2).
// The reference model derives everything from n, the number of clk edges
// since reset release: pixel index = n / CD, x/y from that index, outputs
// from the decode of the state DLY+1 edges earlier.
module tb_vga_sync_sink_core;
    localparam int unsigned CD  = 4;
    localparam int unsigned DLY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] si_rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_start;

    vga_sync_sink_core_if slot ();

    vga_sync_sink_core #(.CD(CD), .DLY(DLY)) dut (
        .clk         (clk),
        .reset       (reset),
        .slot        (slot),
        .x           (x),
        .y           (y),
        .si_rgb      (si_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;

    // reference model state
    int unsigned n = 0;
    bit          model_valid = 0;
    bit          en_m = 1;
    bit          prev_en = 1;
    logic [11:0] prev_si = '0;
    logic [15:0] fc_m = '0;

    function automatic int unsigned m_x(int unsigned k);
        return (k / CD) % 800;
    endfunction
    function automatic int unsigned m_y(int unsigned k);
        return (k / CD / 800) % 525;
    endfunction
    function automatic bit m_tick(int unsigned k);
        return (k % CD) == CD - 1;
    endfunction
    function automatic bit m_hs(int unsigned k);
        return !(m_x(k) >= 656 && m_x(k) <= 751);
    endfunction
    function automatic bit m_vs(int unsigned k);
        return !(m_y(k) >= 490 && m_y(k) <= 491);
    endfunction
    function automatic bit m_vid(int unsigned k);
        return (m_x(k) < 640) && (m_y(k) < 480);
    endfunction
    function automatic logic [31:0] m_rd(logic [1:0] a);
        case (a)
            2'd0:    return {31'b0, en_m};
            2'd1:    return {16'b0, fc_m};
            2'd2:    return 32'(m_y(n));
            default: return {31'b0, (m_y(n) >= 480)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    endtask

    task automatic idle();
        slot.cs      = 1'b0;
        slot.write   = 1'b0;
        slot.read    = 1'b0;
        slot.addr    = '0;
        slot.wr_data = '0;
    endtask

    task automatic peek(input logic [13:0] a, input string name, input logic [31:0] exp);
        slot.addr = a;
        #1;
        chk(name, {32'b0, slot.rd_data}, {32'b0, exp});
    endtask

    // One clk cycle: check rd_data for the inputs already driven, advance the
    // model across the edge, then check every registered/decoded output.
    task automatic step();
        bit          fs;
        bit          clr;
        bit          wr0;
        int          k;
        logic        eh;
        logic        ev;
        logic [11:0] er;
        #1;
        if (model_valid) chk("rd_data", {32'b0, slot.rd_data}, {32'b0, m_rd(slot.addr[1:0])});
        fs  = m_tick(n) && m_x(n) == 0 && m_y(n) == 0;
        clr = slot.cs && slot.write && slot.addr[1:0] == 2'd1;
        wr0 = slot.cs && slot.write && slot.addr[1:0] == 2'd0;
        @(posedge clk);
        if (!reset) begin
            n = 0; en_m = 1; prev_en = 1; prev_si = '0; fc_m = '0; model_valid = 1;
        end else begin
            prev_en = en_m;
            prev_si = si_rgb;
            if (wr0) en_m = slot.wr_data[0];
            if (clr) fc_m = '0;
            else if (fs) fc_m = fc_m + 16'd1;
            n++;
        end
        #1;
        k = int'(n) - 1 - int'(DLY);
        if (n == 0 || k < 0) begin
            eh = 1'b1; ev = 1'b1; er = '0;
        end else begin
            eh = m_hs(k);
            ev = m_vs(k);
            er = (m_vid(k) && prev_en) ? prev_si : 12'h000;
        end
        chk("outputs", {27'b0, x, y, hsync, vsync, rgb, frame_start},
            {27'b0, 11'(m_x(n)), 11'(m_y(n)), eh, ev, er,
             1'(m_tick(n) && m_x(n) == 0 && m_y(n) == 0)});
    endtask

    typedef struct {
        bit          cs;
        bit          wr;
        logic [13:0] addr;
        logic [31:0] data;
        logic [13:0] raddr;
        logic [31:0] exp;
    } slot_vec_t;

    initial begin
        slot_vec_t vec[9];
        int        first_low;
        int        lows;
        int        nz;

        vec[0] = '{1, 1, 14'h0000, 32'h0000_0000, 14'd0, 32'd0};
        vec[1] = '{0, 1, 14'h0000, 32'h0000_0001, 14'd0, 32'd0};
        vec[2] = '{1, 0, 14'h0000, 32'h0000_0001, 14'd0, 32'd0};
        vec[3] = '{1, 1, 14'h3FFC, 32'h0000_0001, 14'd0, 32'd1};
        vec[4] = '{1, 1, 14'h0002, 32'h0000_0000, 14'd0, 32'd1};
        vec[5] = '{1, 1, 14'h0003, 32'h0000_0000, 14'd0, 32'd1};
        vec[6] = '{1, 1, 14'h0000, 32'hFFFF_FFFE, 14'd0, 32'd0};
        vec[7] = '{1, 1, 14'h0000, 32'h0000_0001, 14'd0, 32'd1};
        vec[8] = '{0, 0, 14'h0000, 32'h0000_0000, 14'd3, 32'd0};

        idle();
        si_rgb = 12'hF0A;
        reset  = 1'b0;

        // reset state
        repeat (3) step();
        chk("reset_sync_rgb", {48'b0, hsync, vsync, rgb, frame_start}, {48'b0, 1'b1, 1'b1, 12'h000, 1'b0});
        peek(14'd0, "reset_en", 32'd1);
        peek(14'd1, "reset_fcnt", 32'd0);
        peek(14'd2, "reset_y", 32'd0);

        // first frame_start CD cycles after release
        reset = 1'b1;
        slot.addr = '0;
        repeat (CD - 1) step();
        chk("first_frame_start", {52'b0, frame_start, x}, {52'b0, 1'b1, 11'd0});
        step();
        chk("after_first_tick", {52'b0, frame_start, x}, {52'b0, 1'b0, 11'd1});
        peek(14'd1, "fcnt_one_frame", 32'd1);

        // clear written in the frame_start cycle wins
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (CD - 1) step();
        chk("fs_before_clear", {63'b0, frame_start}, 64'd1);
        slot.cs = 1'b1; slot.write = 1'b1; slot.addr = 14'd1; slot.wr_data = 32'hFFFF_FFFF;
        step();
        idle();
        peek(14'd1, "fcnt_clear_wins", 32'd0);

        // slot register vectors
        for (int i = 0; i < 9; i++) begin
            slot.cs = vec[i].cs; slot.write = vec[i].wr;
            slot.addr = vec[i].addr; slot.wr_data = vec[i].data;
            step();
            idle();
            peek(vec[i].raddr, $sformatf("slot_vec%0d", i), vec[i].exp);
        end

        // random stream over three lines from a fresh reset
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        first_low = -1;
        lows = 0;
        for (int i = 0; i < 3 * 800 * CD + 50; i++) begin
            si_rgb       = 12'($urandom);
            slot.cs      = ($urandom_range(0, 63) == 0);
            slot.write   = 1'b1;
            slot.read    = 1'($urandom);
            slot.addr    = 14'($urandom);
            slot.wr_data = $urandom;
            step();
            if (hsync == 1'b0) begin
                if (first_low < 0) first_low = int'(n);
                if (n <= 800 * CD) lows++;
            end
            if (n == 800 * CD) chk("line_wrap_y", {53'b0, y}, 64'd1);
        end
        chk("hsync_first_low", 64'(first_low), 64'(656 * CD + DLY + 1));
        chk("hsync_low_len", 64'(lows), 64'(96 * CD));

        // disable output mid-line
        slot.cs = 1'b1; slot.write = 1'b1; slot.addr = 14'd0; slot.wr_data = 32'd0;
        step();
        idle();
        peek(14'd0, "en_readback_off", 32'd0);
        nz = 0;
        for (int i = 0; i < 200; i++) begin
            si_rgb = 12'($urandom) | 12'h001;
            step();
            if (i > 0 && rgb != 12'h000) nz++;
        end
        chk("en_off_rgb_zero", 64'(nz), 64'd0);
        slot.cs = 1'b1; slot.write = 1'b1; slot.addr = 14'd0; slot.wr_data = 32'd1;
        step();
        idle();

        // reset mid-frame at x=300
        for (int i = 0; i < 6000 && !(m_x(n) == 300 && m_y(n) >= 1 && n % CD == 0); i++) begin
            si_rgb = 12'($urandom);
            step();
        end
        chk("reached_x300", {53'b0, x}, 64'd300);
        reset = 1'b0;
        repeat (5) step();
        chk("midframe_reset", {27'b0, x, y, hsync, vsync, rgb, frame_start},
            {27'b0, 11'd0, 11'd0, 1'b1, 1'b1, 12'h000, 1'b0});
        peek(14'd0, "midframe_reset_en", 32'd1);
        reset = 1'b1;
        slot.addr = '0;
        repeat (CD - 1) step();
        chk("restart_frame_start", {41'b0, frame_start, x, y}, {41'b0, 1'b1, 11'd0, 11'd0});
        step();
        chk("restart_x", {53'b0, x}, 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
